// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared state encodings, grant IDs and counter width for mem_arbiter
package mem_arbiter_pkg;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_BUSY_I = 2'b01;
  localparam logic [1:0] ST_BUSY_D = 2'b10;
  localparam logic [1:0] ST_RESP   = 2'b11;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  localparam int LAT_W = 4;

endpackage

// File: rtl/mem_arbiter_lat_counter.sv
// rtl/mem_arbiter_lat_counter.sv - loadable down-counter on single-bit dff cells
module dff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) q <= 1'b0;
    else     q <= d;
  end

endmodule

module lat_counter
  import mem_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [LAT_W-1:0] q;
  logic [LAT_W-1:0] d;

  always_comb begin
    d = q;
    if (load)     d = load_val;
    else if (dec) d = q - LAT_W'(1);
  end

  for (genvar i = 0; i < LAT_W; i++) begin : g_bit
    dff u_dff (.clk(clk), .rst(rst), .d(d[i]), .q(q[i]));
  end

  assign zero = (q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IF/D arbiter sequencing the single-ported memory with fixed latency
// Define MEM_ARB_RR_EN for round-robin on contention; default is fixed priority D over IF.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_done,
  output logic [15:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_done,
  output logic [15:0] d_rdata,
  output logic        d_err,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
    $error("mem_arbiter: MEM_LAT must be in 1..15");
  end

  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);

  logic [1:0]  state;
  logic        gnt;
  logic        last_grant;
  logic        lat_wr;
  logic [15:0] lat_addr;
  logic [15:0] lat_wdata;
  logic [15:0] resp_data;
  logic        resp_err;

  logic        any_req;
  logic        pick;
  logic [15:0] pick_addr;
  logic        busy;
  logic        cnt_load;
  logic        cnt_dec;
  logic        cnt_zero;

  always_comb begin
    any_req = if_req | d_req;
`ifdef MEM_ARB_RR_EN
    if (if_req && d_req) pick = ~last_grant;
    else                 pick = d_req ? GNT_D : GNT_I;
`else
    pick = d_req ? GNT_D : GNT_I;
`endif
    pick_addr = (pick == GNT_D) ? d_addr : if_addr;
  end

`ifndef MEM_ARB_RR_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  assign busy     = (state == ST_BUSY_I) || (state == ST_BUSY_D);
  assign cnt_load = (state == ST_IDLE) && any_req && !pick_addr[0];
  assign cnt_dec  = busy && !cnt_zero;

  lat_counter u_lat_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (LAT_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      gnt        <= GNT_I;
      last_grant <= GNT_D;
      lat_wr     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            gnt        <= pick;
            last_grant <= pick;
            lat_addr   <= pick_addr;
            lat_wr     <= (pick == GNT_D) ? d_wr : 1'b0;
            lat_wdata  <= (pick == GNT_D) ? d_wdata : 16'h0000;
            // Misaligned word address never reaches the memory.
            if (pick_addr[0]) begin
              state     <= ST_RESP;
              resp_err  <= 1'b1;
              resp_data <= 16'h0000;
            end else begin
              state    <= (pick == GNT_D) ? ST_BUSY_D : ST_BUSY_I;
              resp_err <= 1'b0;
            end
          end
        end
        ST_BUSY_I, ST_BUSY_D: begin
          if (cnt_zero) begin
            resp_data <= lat_wr ? 16'h0000 : mem_rdata;
            state     <= ST_RESP;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_en    = busy;
  assign mem_wr    = busy & lat_wr;
  assign mem_addr  = busy ? lat_addr : 16'h0000;
  assign mem_wdata = busy ? lat_wdata : 16'h0000;

  assign if_done  = (state == ST_RESP) && (gnt == GNT_I);
  assign d_done   = (state == ST_RESP) && (gnt == GNT_D);
  assign if_rdata = if_done ? resp_data : 16'h0000;
  assign d_rdata  = d_done ? resp_data : 16'h0000;
  assign if_err   = if_done & resp_err;
  assign d_err    = d_done & resp_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized bench for mem_arbiter against a transaction-timeline model
module tb_mem_arbiter;

  localparam int L = 2;
  localparam int N_CYC = 4000;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_done;
  logic [15:0] if_rdata;
  logic        if_err;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_done;
  logic [15:0] d_rdata;
  logic        d_err;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(L)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] rnd_addr();
    logic [15:0] a;
    a = 16'($urandom);
    a[0] = ($urandom_range(0, 3) == 0);
    return a;
  endfunction

  // Model: one transaction at a time, described by its accept cycle and attributes.
  bit          m_active;
  int          m_acc;
  int          m_end;
  bit          m_gnt;
  bit          m_mis;
  bit          m_wr;
  bit          m_last;
  logic [15:0] m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata;

  bit if_renew;
  bit d_renew;

  logic        e_en, e_wr, e_idone, e_ddone, e_err;
  logic [15:0] e_addr, e_wd, e_rd;

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_mem_en", mem_en, 1'b0);
    check("reset_mem_wr", mem_wr, 1'b0);
    check("reset_mem_addr", mem_addr, 16'h0);
    check("reset_mem_wdata", mem_wdata, 16'h0);
    check("reset_if_done", if_done, 1'b0);
    check("reset_d_done", d_done, 1'b0);
    check("reset_if_rdata", if_rdata, 16'h0);
    check("reset_d_rdata", d_rdata, 16'h0);
    check("reset_if_err", if_err, 1'b0);
    check("reset_d_err", d_err, 1'b0);

    m_active = 1'b0;
    m_last   = 1'b1;
    m_rdata  = '0;
    if_renew = 1'b1;
    d_renew  = 1'b1;

    for (int c = 0; c < N_CYC; c++) begin
      @(posedge clk);
      #1;
      rst = (c > 0) && ($urandom_range(0, 149) == 0);
      if (!if_req || if_renew) begin
        if_req   = ($urandom_range(0, 4) < 3);
        if_addr  = rnd_addr();
        if_renew = 1'b0;
      end
      if (!d_req || d_renew) begin
        d_req   = ($urandom_range(0, 4) < 3);
        d_wr    = $urandom_range(0, 1);
        d_addr  = rnd_addr();
        d_wdata = 16'($urandom);
        d_renew = 1'b0;
      end
      mem_rdata = 16'($urandom);
      #1;

      e_en = 0; e_wr = 0; e_addr = '0; e_wd = '0;
      e_idone = 0; e_ddone = 0; e_rd = '0; e_err = 0;
      if (m_active) begin
        if (!m_mis && c >= m_acc + 1 && c <= m_acc + L) begin
          e_en = 1'b1; e_wr = m_wr; e_addr = m_addr; e_wd = m_wdata;
          if (c == m_acc + L) m_rdata = m_wr ? 16'h0 : mem_rdata;
        end
        if (c == m_end) begin
          e_idone = !m_gnt;
          e_ddone = m_gnt;
          e_rd    = m_rdata;
          e_err   = m_mis;
        end
      end

      check("mem_en", mem_en, e_en);
      check("mem_wr", mem_wr, e_wr);
      check("mem_addr", mem_addr, e_addr);
      check("mem_wdata", mem_wdata, e_wd);
      check("if_done", if_done, e_idone);
      check("d_done", d_done, e_ddone);
      check("if_rdata", if_rdata, e_idone ? e_rd : 16'h0);
      check("d_rdata", d_rdata, e_ddone ? e_rd : 16'h0);
      check("if_err", if_err, e_idone & e_err);
      check("d_err", d_err, e_ddone & e_err);

      if (e_idone) if_renew = 1'b1;
      if (e_ddone) d_renew = 1'b1;

      if (rst) begin
        m_active = 1'b0;
        m_last   = 1'b1;
        if_renew = 1'b1;
        d_renew  = 1'b1;
      end else if (m_active) begin
        if (c == m_end) m_active = 1'b0;
      end else if (if_req || d_req) begin
`ifdef MEM_ARB_RR_EN
        if (if_req && d_req) m_gnt = !m_last;
        else                 m_gnt = d_req;
`else
        m_gnt = d_req;
`endif
        m_last   = m_gnt;
        m_active = 1'b1;
        m_acc    = c;
        m_addr   = m_gnt ? d_addr : if_addr;
        m_wr     = m_gnt ? d_wr : 1'b0;
        m_wdata  = m_gnt ? d_wdata : 16'h0;
        m_mis    = m_addr[0];
        m_rdata  = '0;
        m_end    = m_mis ? c + 1 : c + L + 1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequencing controller for the single-ported `memory2c` instance.
- Shares the memory between the instruction-fetch requester (IF) and the load/store requester (D).
- Each access is held on the memory port for MEM_LAT cycles, then returned with a one-cycle done pulse.
- Sits between the fetch/memory stages and the memory model; also flags misaligned word addresses.

Parameters:
- MEM_LAT, 1, memory access latency in cycles. Legal range 1..15; any other value is an elaboration error.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch request; held until if_done
- if_addr  in  16  fetch word address
- if_done  out  1  one-cycle response pulse to fetch
- if_rdata  out  16  fetched instruction, valid with if_done
- if_err  out  1  misaligned fetch, valid with if_done
- d_req  in  1  data request; held until d_done
- d_wr  in  1  1 = store, 0 = load
- d_addr  in  16  data word address
- d_wdata  in  16  store data
- d_done  out  1  one-cycle response pulse to data
- d_rdata  out  16  load data, valid with d_done
- d_err  out  1  misaligned data access, valid with d_done
- mem_en  out  1  memory enable
- mem_wr  out  1  memory write
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data

Behaviour:
- Clock/reset: one clock, clk; rst is synchronous, active-high.
- States: IDLE, BUSY_I, BUSY_D, RESP. Reset gives IDLE, lat_cnt=0, all outputs 0, last_grant=D.
- IDLE: requests are sampled only in this state.
  - No request: stay in IDLE.
  - Grant: latch addr, wr and wdata of the granted requester.
  - Aligned (addr[0]=0): go to BUSY_x with lat_cnt=MEM_LAT-1.
  - Misaligned (addr[0]=1): go straight to RESP with err=1 and no memory access.
- BUSY_x:
  - mem_en=1; mem_addr and mem_wdata come from the latched regs; mem_wr = latched wr (always 0 in BUSY_I).
  - lat_cnt decrements each cycle.
  - When lat_cnt==0: capture mem_rdata (0x0000 for stores) into the response register and go to RESP.
- RESP:
  - Exactly one of if_done/d_done is 1, for the requester granted.
  - rdata/err are valid in this cycle; next state is IDLE.
  - Requests seen in RESP are ignored.
- Timing: a request accepted in IDLE at cycle t gives BUSY over t+1..t+MEM_LAT, done at t+MEM_LAT+1, IDLE at t+MEM_LAT+2.
- Throughput: one access per MEM_LAT+2 cycles; holding req through done issues a back-to-back access.
- Priority when both request: D wins (default build); last_grant is updated on every grant.
- Outside BUSY: mem_en=mem_wr=0, mem_addr/mem_wdata=0.
- rdata/err outputs are 0 whenever the corresponding done is 0.
- Reset mid-access:
  - Next cycle is IDLE with mem_en=0; no done is issued.
  - An in-flight store is aborted; the memory's reset handles its own contents.
- Widths: all addresses and data are 16-bit unsigned; no arithmetic on addresses.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined: when both requests are present, grant the requester not in last_grant (round-robin). Since last_grant resets to D, the first contention goes to IF.
- Undefined: fixed priority, D over IF; last_grant is still maintained but unused.

Decomposition:
- Shared defines file mem_arb_defs.vh holds:
  - state encodings (2-bit): IDLE=00, BUSY_I=01, BUSY_D=10, RESP=11
  - grant IDs: GNT_I=0, GNT_D=1
  - LAT_W=4
- One sub-module, lat_counter:
  - loadable 4-bit down-counter built on dff cells
  - inputs clk, rst, load, load_val, dec; output zero flag

Test Plan:
1. MEM_LAT=2; if_req=1, if_addr=0x0004 at cycle 0, mem_rdata=0x1234 → mem_en=1, mem_addr=0x0004, mem_wr=0 in cycles 1-2; if_done=1, if_rdata=0x1234 in cycle 3; d_done stays 0.
2. MEM_LAT=2, default build; if_req (0x0000) and d_req read (0x0010) both at cycle 0, both held → d_done at cycle 3; IF granted at cycle 4, mem_addr=0x0000 in cycles 5-6, if_done at cycle 7.
3. MEM_LAT=2, MEM_ARB_RR_EN; both requests held continuously → grants alternate IF, D, IF, D with done pulses at cycles 3, 7, 11, 15.
4. MEM_LAT=2; d_req=1, d_wr=1, d_addr=0x0020, d_wdata=0xBEEF → mem_wr=1, mem_wdata=0xBEEF in cycles 1-2; d_done=1, d_rdata=0x0000, d_err=0 in cycle 3.
5. d_req read, d_addr=0x0013 at cycle 0 → mem_en=0 throughout; d_done=1, d_err=1, d_rdata=0 in cycle 1; IDLE in cycle 2.
6. MEM_LAT=4; d_req write at cycle 0, rst=1 in cycle 2 → cycle 3: state IDLE, mem_en=0, no d_done ever; after rst drops, an if_req completes normally with MEM_LAT+1 latency.
